// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode codes, FSM state
// type and a helper classifying the modes that always finish in one edge.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  // Hold, load and reserved ignore the step count. Rotates stay multi-step
  // even when the rotate datapath is compiled out, so busy/done timing is preserved.
  function automatic logic is_single_step(input logic [2:0] mode);
    return (mode == MODE_HOLD) || (mode == MODE_LOAD) || (mode == MODE_RSVD);
  endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational one-step shifter for the universal shift register.
// Rotate modes exist only when USR_ROTATE_EN is defined; otherwise they hold.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [2:0]       i_mode,
  input  logic             i_msb_in,
  input  logic             i_lsb_in,
  input  logic [WIDTH-1:0] i_par,
  output logic [WIDTH-1:0] o_a_next
);

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    o_a_next = i_a;
    case (i_mode)
      MODE_SHR:  o_a_next = {i_msb_in, i_a[WIDTH-1:1]};
      MODE_SHL:  o_a_next = {i_a[WIDTH-2:0], i_lsb_in};
      MODE_LOAD: o_a_next = i_par;
      MODE_ASR:  o_a_next = {i_a[WIDTH-1], i_a[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
      MODE_ROR:  o_a_next = {i_a[0], i_a[WIDTH-1:1]};
      MODE_ROL:  o_a_next = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
`endif
      default:   o_a_next = i_a;
    endcase
  end

endmodule

// File: rtl/shift_register_univ_n.sv
// Universal shift register with multi-step shift and start/busy/done handshake.
// Optional rotate modes are enabled by defining USR_ROTATE_EN (see usr_step).
module shift_register_univ_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             clear_b,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] I_par,
  input  logic             MSB_in,
  input  logic             LSB_in,
  output logic [WIDTH-1:0] A_par,
  output logic             MSB_out,
  output logic             LSB_out,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [2:0]       r_mode;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_step_mode;
  logic [WIDTH-1:0] w_a_next;

  // The first step uses the live mode on the accepting edge; later steps use the latch.
  assign w_step_mode = (r_state == IDLE) ? mode : r_mode;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .i_a      (r_a),
    .i_mode   (w_step_mode),
    .i_msb_in (MSB_in),
    .i_lsb_in (LSB_in),
    .i_par    (I_par),
    .o_a_next (w_a_next)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      r_state <= IDLE;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
      r_a     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode <= mode;
            if (amt != '0) r_a <= w_a_next;
            if (!is_single_step(mode) && (amt > AMT_W'(1))) begin
              r_cnt   <= amt - AMT_W'(1);
              r_state <= RUN;
              r_busy  <= 1'b1;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        RUN: begin
          r_a   <= w_a_next;
          r_cnt <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign A_par   = r_a;
  assign MSB_out = r_a[WIDTH-1];
  assign LSB_out = r_a[0];
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_shift_register_univ_n.sv
// Self-checking bench for shift_register_univ_n: directed scenarios plus random
// traffic, all checked against an operation-level reference model.
module tb_shift_register_univ_n;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             clear_b;
  logic [2:0]       mode;
  logic             start;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] I_par;
  logic             MSB_in, LSB_in;
  logic [WIDTH-1:0] A_par;
  logic             MSB_out, LSB_out, busy, done;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: register value, steps still to run, the latched operation.
  int m_a;
  int m_rem;
  int m_mode;
  int m_done;

  shift_register_univ_n #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk     (clk),
    .clear_b (clear_b),
    .mode    (mode),
    .start   (start),
    .amt     (amt),
    .I_par   (I_par),
    .MSB_in  (MSB_in),
    .LSB_in  (LSB_in),
    .A_par   (A_par),
    .MSB_out (MSB_out),
    .LSB_out (LSB_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One step described arithmetically on an 8-bit value.
  function automatic int ref_step(int a, int md, int msb, int lsb, int par);
    case (md)
      1: return a / 2 + msb * 128;
      2: return (a * 2) % 256 + lsb;
      3: return par;
`ifdef USR_ROTATE_EN
      4: return a / 2 + (a % 2) * 128;
      5: return (a * 2) % 256 + a / 128;
`endif
      6: return a / 2 + ((a >= 128) ? 128 : 0);
      default: return a;
    endcase
  endfunction

  function automatic int total_steps(int md, int n);
    if (md == 0 || md == 3 || md == 7) return (n == 0) ? 0 : 1;
    return n;
  endfunction

  task automatic model_reset();
    m_a = 0; m_rem = 0; m_mode = 0; m_done = 0;
  endtask

  task automatic model_edge();
    int n;
    m_done = 0;
    if (m_rem == 0) begin
      if (start) begin
        m_mode = int'(mode);
        n = total_steps(m_mode, int'(amt));
        if (n > 0) m_a = ref_step(m_a, m_mode, int'(MSB_in), int'(LSB_in), int'(I_par));
        m_rem = (n > 1) ? n - 1 : 0;
        if (m_rem == 0) m_done = 1;
      end
    end else begin
      m_a = ref_step(m_a, m_mode, int'(MSB_in), int'(LSB_in), int'(I_par));
      m_rem--;
      if (m_rem == 0) m_done = 1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".A"},    32'(A_par),   32'(m_a));
    check({tag, ".busy"}, 32'(busy),    32'(m_rem > 0));
    check({tag, ".done"}, 32'(done),    32'(m_done));
    check({tag, ".msb"},  32'(MSB_out), 32'(m_a / 128));
    check({tag, ".lsb"},  32'(LSB_out), 32'(m_a % 2));
  endtask

  // Drive inputs, take one clock edge, advance the model and compare after the edge.
  task automatic cycle(input string tag, input logic s, input logic [2:0] md,
                       input logic [AMT_W-1:0] n, input logic [WIDTH-1:0] par,
                       input logic msb, input logic lsb);
    start = s; mode = md; amt = n; I_par = par; MSB_in = msb; LSB_in = lsb;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 3'b000, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    clear_b = 1'b1;
    start = 1'b1; mode = 3'b101; amt = 4'hF; I_par = 8'h5A; MSB_in = 1'b1; LSB_in = 1'b1;
    #2 clear_b = 1'b0;
    model_reset();
    #1;
    check("rst.A", 32'(A_par), 32'h00);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.done", 32'(done), 32'h0);
    @(posedge clk); @(posedge clk);
    #2;
    start = 1'b0;
    clear_b = 1'b1;
    idle("rst_idle", 3);

    // Parallel load ignores amt
    cycle("load", 1'b1, 3'b011, 4'd5, 8'hB4, 1'b0, 1'b0);
    check("load.val", 32'(A_par), 32'hB4);
    idle("load_after", 1);

    // Shift right with a start pulse while busy that must be ignored
    cycle("shr1", 1'b1, 3'b001, 4'd3, 8'h00, 1'b1, 1'b0);
    check("shr1.val", 32'(A_par), 32'hDA);
    cycle("shr2", 1'b1, 3'b011, 4'd1, 8'h00, 1'b1, 1'b0);
    check("shr2.val", 32'(A_par), 32'hED);
    cycle("shr3", 1'b0, 3'b000, 4'd0, 8'h00, 1'b1, 1'b0);
    check("shr3.val", 32'(A_par), 32'hF6);
    idle("shr_after", 2);
    check("shr_ignored", 32'(A_par), 32'hF6);

    // Arithmetic shift, then zero-amount shift left
    cycle("ld90", 1'b1, 3'b011, 4'd1, 8'h90, 1'b0, 1'b0);
    cycle("asr1", 1'b1, 3'b110, 4'd2, 8'h00, 1'b0, 1'b1);
    cycle("asr2", 1'b0, 3'b000, 4'd0, 8'h00, 1'b0, 1'b1);
    check("asr.val", 32'(A_par), 32'hE4);
    cycle("amt0", 1'b1, 3'b010, 4'd0, 8'h00, 1'b0, 1'b1);
    check("amt0.val", 32'(A_par), 32'hE4);
    check("amt0.done", 32'(done), 32'h1);

    // Rotate left by four
    cycle("ldB4", 1'b1, 3'b011, 4'd1, 8'hB4, 1'b0, 1'b0);
    cycle("rol", 1'b1, 3'b101, 4'd4, 8'h00, 1'b0, 1'b0);
    idle("rol_run", 3);
`ifdef USR_ROTATE_EN
    check("rol.val", 32'(A_par), 32'h4B);
`else
    check("rol.val", 32'(A_par), 32'hB4);
`endif
    check("rol.done", 32'(done), 32'h1);

    // Abort a long shift with an asynchronous reset
    cycle("ldFF", 1'b1, 3'b011, 4'd1, 8'hFF, 1'b0, 1'b0);
    cycle("abort_shl", 1'b1, 3'b010, 4'd10, 8'h00, 1'b0, 1'b0);
    idle("abort_run", 3);
    clear_b = 1'b0;
    model_reset();
    #1;
    check("abort.A", 32'(A_par), 32'h00);
    check("abort.busy", 32'(busy), 32'h0);
    check("abort.done", 32'(done), 32'h0);
    #1 clear_b = 1'b1;
    idle("abort_after", 2);
    cycle("ld3C", 1'b1, 3'b011, 4'd2, 8'h3C, 1'b0, 1'b0);
    check("ld3C.val", 32'(A_par), 32'h3C);

    // Random traffic, including back-to-back starts and amt beyond WIDTH
    for (int i = 0; i < 600; i++) begin
      cycle("rand", ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
